std_shared_divmod_sched: RTL and testbench

- Round-robin scheduler that time-shares one divide/modulo datapath among NUM_REQ requesters.
- Each requester uses the standard go/done handshake. The granted requester gets both quotient and remainder from one operation.
- Configurable LATENCY models a multi-cycle divider, so generated designs can share one divider instead of instantiating a combinational divider per use site.

---
 rtl/std_shared_divmod_sched.sv | 196 +++++++++++++++++++
 tb/tb_std_shared_divmod_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/std_shared_divmod_sched.sv
// Round-robin scheduler sharing one divide/modulo datapath among NUM_REQ go/done requesters.
// Optional macro STD_SHARED_DIVMOD_DIVZERO_ERR_EN adds a div_zero flag output and a simulation-only $error.
module std_shared_divmod_sched #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2,
    parameter int LATENCY = 2,
    parameter int SIGNED  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         go,
    input  logic [NUM_REQ*WIDTH-1:0]   left,
    input  logic [NUM_REQ*WIDTH-1:0]   right,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [WIDTH-1:0]           out_quotient,
`ifdef STD_SHARED_DIVMOD_DIVZERO_ERR_EN
    output logic [WIDTH-1:0]           out_remainder,
    output logic                       div_zero
`else
    output logic [WIDTH-1:0]           out_remainder
`endif
);

    localparam int PW       = $clog2(NUM_REQ);
    localparam int CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int LAST_CNT = (LATENCY > 0) ? LATENCY - 1 : 0;

    localparam logic [1:0]       S_IDLE     = 2'd0;
    localparam logic [1:0]       S_BUSY     = 2'd1;
    localparam logic [1:0]       S_DONE     = 2'd2;
    localparam logic [CW-1:0]    C_LAST     = CW'(LAST_CNT);
    localparam logic [PW:0]      C_NREQ     = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0]    C_TOP      = PW'(NUM_REQ - 1);
    localparam logic [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         r_state;
    logic [PW-1:0]      r_ptr;
    logic [CW-1:0]      r_cnt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_left;
    logic [WIDTH-1:0]   r_right;

    logic [NUM_REQ-1:0] w_rot;
    logic [PW-1:0]      w_off;
    logic [PW:0]        w_sum;
    logic [PW-1:0]      w_win;
    logic [PW-1:0]      w_next_ptr;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [WIDTH-1:0]   w_sel_left;
    logic [WIDTH-1:0]   w_sel_right;
    logic [WIDTH-1:0]   w_dl;
    logic [WIDTH-1:0]   w_dr;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic               w_any;
    logic               w_finish;

    function automatic logic [2*WIDTH-1:0] f_divmod(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (SIGNED != 0) begin
            // most-negative / -1 overflows; pin the result instead of relying on the operator
            if (a == C_MOST_NEG && b == '1) begin
                q = C_MOST_NEG;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Rotate requests so bit 0 is the pointer position; the lowest set bit wins.
    assign w_rot = NUM_REQ'({go, go} >> r_ptr);
    assign w_any = |go;

    always_comb begin
        w_off = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) w_off = PW'(j);
        end
        w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
        w_win      = (w_sum >= C_NREQ) ? PW'(w_sum - C_NREQ) : w_sum[PW-1:0];
        w_next_ptr = (w_win == C_TOP) ? '0 : w_win + 1'b1;
        w_sel_left  = '0;
        w_sel_right = '0;
        w_grant_oh  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_win == PW'(j)) begin
                w_sel_left    = left[j*WIDTH +: WIDTH];
                w_sel_right   = right[j*WIDTH +: WIDTH];
                w_grant_oh[j] = 1'b1;
            end
        end
    end

    // With zero latency the result is produced straight from the operands being captured.
    assign w_dl = (LATENCY == 0) ? w_sel_left  : r_left;
    assign w_dr = (LATENCY == 0) ? w_sel_right : r_right;
    assign {w_q, w_r} = f_divmod(w_dl, w_dr);

    assign w_finish = ((r_state == S_IDLE) && w_any && (LATENCY == 0)) ||
                      ((r_state == S_BUSY) && (r_cnt == C_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_left  <= '0;
            r_right <= '0;
        end else begin
            r_done <= '0;
            if (w_finish) begin
                r_quot <= w_q;
                r_rem  <= w_r;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_grant_oh;
                        r_ptr   <= w_next_ptr;
                        r_left  <= w_sel_left;
                        r_right <= w_sel_right;
                        r_cnt   <= '0;
                        if (LATENCY == 0) begin
                            r_done  <= w_grant_oh;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == C_LAST) begin
                        r_done  <= r_grant;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant         = r_grant;
    assign done          = r_done;
    assign out_quotient  = r_quot;
    assign out_remainder = r_rem;

`ifdef STD_SHARED_DIVMOD_DIVZERO_ERR_EN
    logic          r_div_zero;
    logic [PW-1:0] r_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_zero <= 1'b0;
            r_win      <= '0;
        end else begin
            r_div_zero <= w_finish && (w_dr == '0);
            if (r_state == S_IDLE && w_any) r_win <= w_win;
        end
    end

    assign div_zero = r_div_zero;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && r_state == S_DONE && r_div_zero)
            $error("std_shared_divmod_sched: divide by zero from requester %0d", r_win);
    end
`endif
`endif

endmodule

// File: tb/tb_std_shared_divmod_sched.sv
// Bench for std_shared_divmod_sched: unsigned LATENCY=2 and signed LATENCY=0 instances, scoreboard-checked.
module tb_std_shared_divmod_sched;

    localparam int W     = 32;
    localparam int NR    = 2;
    localparam int NI    = 2;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    typedef struct packed {
        logic [0:0]   inst;
        logic [0:0]   req;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NR-1:0]   go_s[NI];
    logic [NR*W-1:0] left_s[NI];
    logic [NR*W-1:0] right_s[NI];
    logic [NR-1:0]   grant_s[NI];
    logic [NR-1:0]   done_s[NI];
    logic [W-1:0]    quot_s[NI];
    logic [W-1:0]    rem_s[NI];
    logic            dz_s[NI];

    logic [NR-1:0] grant_a, done_a, grant_b, done_b;
    logic [W-1:0]  quot_a, rem_a, quot_b, rem_b;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   act[NI][NR];

    std_shared_divmod_sched #(.WIDTH(W), .NUM_REQ(NR), .LATENCY(LAT_A), .SIGNED(0)) u_dut_a (
        .clk(clk), .reset(reset), .go(go_s[0]), .left(left_s[0]), .right(right_s[0]),
        .grant(grant_a), .done(done_a), .out_quotient(quot_a),
`ifdef STD_SHARED_DIVMOD_DIVZERO_ERR_EN
        .out_remainder(rem_a), .div_zero(dz_s[0])
`else
        .out_remainder(rem_a)
`endif
    );

    std_shared_divmod_sched #(.WIDTH(W), .NUM_REQ(NR), .LATENCY(LAT_B), .SIGNED(1)) u_dut_b (
        .clk(clk), .reset(reset), .go(go_s[1]), .left(left_s[1]), .right(right_s[1]),
        .grant(grant_b), .done(done_b), .out_quotient(quot_b),
`ifdef STD_SHARED_DIVMOD_DIVZERO_ERR_EN
        .out_remainder(rem_b), .div_zero(dz_s[1])
`else
        .out_remainder(rem_b)
`endif
    );

`ifndef STD_SHARED_DIVMOD_DIVZERO_ERR_EN
    assign dz_s[0] = 1'b0;
    assign dz_s[1] = 1'b0;
`endif
    assign grant_s[0] = grant_a;
    assign done_s[0]  = done_a;
    assign quot_s[0]  = quot_a;
    assign rem_s[0]   = rem_a;
    assign grant_s[1] = grant_b;
    assign done_s[1]  = done_b;
    assign quot_s[1]  = quot_b;
    assign rem_s[1]   = rem_b;

    // Reference arithmetic: 64-bit integer math, then truncated to W bits.
    function automatic void ref_dm(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int lat_of(input int n);
        return (n == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic check(input string name, input int n, input logic [W-1:0] actual,
                         input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %0h want %0h", name, n, cyc, actual, expected);
        end
    endtask

    task automatic push_exp(input int n, input int i, input logic [W-1:0] q,
                            input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.inst = n[0];
        e.req  = i[0];
        e.q    = q;
        e.r    = r;
        e.dz   = dz;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic [NR-1:0] m_prev_g[NI];
    logic [NR-1:0] m_prev_d[NI];
    int            m_ptr[NI];
    int            m_gcyc[NI];

    task automatic mon_step(input int n);
        logic [NR-1:0] eg, ed;
        int w, idx, ri;
        if (reset) begin
            check("rst_grant", n, W'(grant_s[n]), '0);
            check("rst_done", n, W'(done_s[n]), '0);
            check("rst_quot", n, quot_s[n], '0);
            check("rst_rem", n, rem_s[n], '0);
            check("rst_divzero", n, W'(dz_s[n]), '0);
            for (int k = exp_q.size() - 1; k >= 0; k--)
                if (exp_q[k].inst == n[0]) exp_q.delete(k);
            m_ptr[n]    = 0;
            m_prev_g[n] = '0;
            m_prev_d[n] = '0;
            return;
        end
        eg = '0;
        if (m_prev_g[n] == '0) begin
            for (int k = 0; k < NR; k++) begin
                w = (m_ptr[n] + k) % NR;
                if (go_s[n][w]) begin
                    eg[w]     = 1'b1;
                    m_ptr[n]  = (w + 1) % NR;
                    m_gcyc[n] = cyc;
                    break;
                end
            end
        end else if (m_prev_d[n] == '0) begin
            eg = m_prev_g[n];
        end
        ed = (eg != '0 && (cyc - m_gcyc[n]) == lat_of(n)) ? eg : '0;
        check("grant", n, W'(grant_s[n]), W'(eg));
        check("done", n, W'(done_s[n]), W'(ed));
        if (ed != '0) begin
            ri  = ed[1] ? 1 : 0;
            idx = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (exp_q[k].inst == n[0] && exp_q[k].req == ri[0]) begin
                    idx = k;
                    break;
                end
            end
            checks++;
            if (idx < 0) begin
                errors++;
                $display("FAIL no_expect inst%0d req%0d cycle %0d: got done with empty queue", n, ri, cyc);
            end else begin
                check("quotient", n, quot_s[n], exp_q[idx].q);
                check("remainder", n, rem_s[n], exp_q[idx].r);
`ifdef STD_SHARED_DIVMOD_DIVZERO_ERR_EN
                check("div_zero", n, W'(dz_s[n]), W'(exp_q[idx].dz));
`endif
                exp_q.delete(idx);
            end
        end
        m_prev_g[n] = eg;
        m_prev_d[n] = ed;
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        for (int n = 0; n < NI; n++) mon_step(n);
    end

    // ---------------- drivers ----------------
    task automatic start_req(input int n, input int i);
        logic [W-1:0] l, r, q, rm;
        case ($urandom_range(0, 5))
            0:       r = '0;
            1:       r = 32'd1;
            2:       r = '1;
            3:       r = W'($urandom_range(1, 15));
            default: r = $urandom;
        endcase
        case ($urandom_range(0, 3))
            0:       l = 32'h8000_0000;
            1:       l = W'($urandom_range(0, 100));
            default: l = $urandom;
        endcase
        left_s[n][i*W +: W]  = l;
        right_s[n][i*W +: W] = r;
        go_s[n][i]           = 1'b1;
        act[n][i]            = 1'b1;
        ref_dm(n == 1, l, r, q, rm);
        push_exp(n, i, q, rm, r == '0);
    endtask

    task automatic run_traffic(input int ncyc, input int start_pct, input int keep_pct,
                               input bit drop_en);
        repeat (ncyc) begin
            @(negedge clk);
            for (int n = 0; n < NI; n++) begin
                for (int i = 0; i < NR; i++) begin
                    if (!act[n][i]) begin
                        if (start_pct > 0 && $urandom_range(0, 99) < start_pct) start_req(n, i);
                    end else if (done_s[n][i]) begin
                        if ($urandom_range(0, 99) < keep_pct) begin
                            start_req(n, i);
                        end else begin
                            go_s[n][i] = 1'b0;
                            act[n][i]  = 1'b0;
                        end
                    end else if (grant_s[n][i]) begin
                        left_s[n][i*W +: W]  = $urandom;
                        right_s[n][i*W +: W] = $urandom;
                        if (drop_en && $urandom_range(0, 3) == 0) go_s[n][i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int k;
        bit busy;
        for (k = 0; k < 100; k++) begin
            busy = 1'b0;
            for (int n = 0; n < NI; n++)
                for (int i = 0; i < NR; i++) busy |= act[n][i];
            if (!busy) break;
            run_traffic(1, 0, 0, 1'b0);
        end
        checks++;
        if (k == 100) begin
            errors++;
            $display("FAIL drain_timeout: got requests still pending after %0d cycles want none", k);
        end
    endtask

    task automatic issue(input int n, input int i, input logic [W-1:0] l, input logic [W-1:0] r,
                         input logic [W-1:0] eq, input logic [W-1:0] er);
        int k;
        @(negedge clk);
        left_s[n][i*W +: W]  = l;
        right_s[n][i*W +: W] = r;
        go_s[n][i]           = 1'b1;
        push_exp(n, i, eq, er, r == '0);
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (grant_s[n][i]) begin
                left_s[n][i*W +: W]  = $urandom;
                right_s[n][i*W +: W] = $urandom;
            end
            if (done_s[n][i]) break;
        end
        checks++;
        if (k == 20) begin
            errors++;
            $display("FAIL done_timeout inst%0d req%0d: got no done want done within 20 cycles", n, i);
        end
        go_s[n][i] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int n = 0; n < NI; n++) begin
            go_s[n]     = '0;
            left_s[n]   = '0;
            right_s[n]  = '0;
            m_prev_g[n] = '0;
            m_prev_d[n] = '0;
            m_ptr[n]    = 0;
            m_gcyc[n]   = 0;
            for (int i = 0; i < NR; i++) act[n][i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;

        issue(0, 0, 32'd100, 32'd7, 32'd14, 32'd2);
        issue(0, 1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234);
        issue(0, 1, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15);
        issue(1, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        issue(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        issue(1, 0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234);
        issue(1, 1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        issue(1, 0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);

        run_traffic(400, 30, 50, 1'b1);
        drain();

        // Both requesters hold go continuously: grants must alternate.
        run_traffic(60, 100, 100, 1'b0);
        drain();

        // Abort an operation on inst 0 req1 two cycles after its go.
        @(negedge clk);
        left_s[0][W +: W]  = 32'd500;
        right_s[0][W +: W] = 32'd3;
        go_s[0][1]         = 1'b1;
        push_exp(0, 1, 32'd166, 32'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset      = 1'b1;
        go_s[0][1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        start_req(0, 0);
        start_req(0, 1);
        drain();

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect: got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test want end before 200000 time units");
        $fatal(1, "bench timeout");
    end

endmodule
